disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 The block SHALL take parameter REFRESH_DIV, default 100000, meaning clk cycles per digit-advance tick (legal values >= 2).
REQ-002 The block SHALL take parameter DEB_CYCLES, default 500000, meaning clk cycles a synchronized button level must hold before it is accepted (legal values >= 2).
REQ-003 clk  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 btn  input  4  raw asynchronous push buttons; btn[i] requests a load of digit i.
REQ-006 sw_val  input  4  hex value to load into the requested digit.
REQ-007 anodes  output  4  active-low digit enables; at most one bit SHALL be low at any time.
REQ-008 dig_code  output  5  {blank, value[3:0]} for the enabled digit, feeding the seven-segment decoder; blank=1 means segments off.
REQ-009 load_ack  output  4  one-hot, single-cycle pulse; bit i high means digit i was written this cycle.

Function
REQ-010 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 A rising edge of a button's accepted (debounced) level SHALL set that button's pending bit; holding the button SHALL NOT set it again.
REQ-012 Pending bits SHALL be arbitrated by fixed priority, index 3 highest, with at most one grant per cycle.
REQ-013 On a grant of index i, the block SHALL write digit[i] <= {1'b0, sw_val}, clear pending[i], and pulse load_ack[i] on the next rising edge.
REQ-014 If a new edge for button i arrives in the same cycle that i is granted, the set SHALL win and pending[i] SHALL remain 1.
REQ-015 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL be high for the one cycle in which the count equals REFRESH_DIV-1.
REQ-016 The scan FSM SHALL have states OFF, D0, D1, D2, D3 with transitions OFF->D0 and D0->D1->D2->D3->D0, each taken only on tick.
REQ-017 anodes SHALL be registered as OFF=1111, D0=1110, D1=1101, D2=1011, D3=0111.
REQ-018 dig_code SHALL be 5'b11111 in OFF and digit[n] in Dn, selected combinationally from registered state so that it changes on the same edge as anodes.
REQ-019 A write to the digit currently displayed SHALL appear on dig_code on the same edge that asserts load_ack.
REQ-020 Arbitration and loading SHALL be independent of scan state and tick.

Reset
REQ-021 While rst_n=0, the block SHALL hold anodes=1111, dig_code=11111, load_ack=0000, state=OFF, all digit[i]=5'b11111 (blank), pending=0, accepted levels=0, and all counters at 0.
REQ-022 Reset asserted mid-operation SHALL discard pending requests immediately, and no load_ack SHALL follow reset release without a new press.
REQ-023 After rst_n deasserts, the first tick SHALL occur REFRESH_DIV cycles later.

Configuration
REQ-024 With BTN_DEBOUNCE_EN defined, each button SHALL use a counter that clears whenever the synchronized level equals the accepted level; when the levels differ, the counter increments, and the accepted level updates when it reaches DEB_CYCLES-1.
REQ-025 Without BTN_DEBOUNCE_EN, the accepted level SHALL equal the synchronized level, DEB_CYCLES SHALL be ignored, and no debounce counters SHALL be built.

Verification (REFRESH_DIV=4, DEB_CYCLES=8)
REQ-026 Release reset with btn=0 -> anodes=1111 for 4 cycles, then 1110/1101/1011/0111/1110 every 4 cycles, with dig_code=11111 throughout.
REQ-027 Set sw_val=A and hold btn=0001 for 30 cycles -> exactly one load_ack=0001 pulse, and dig_code=01010 whenever anodes=1110.
REQ-028 Raise btn=1001 on the same cycle -> load_ack=1000, then load_ack=0001 on the next cycle, and digit3 and digit0 both hold sw_val.
REQ-029 With the macro defined, toggle btn[2] every 3 cycles for 30 cycles, then hold it low -> no load_ack, and digit2 stays blank.
REQ-030 Press btn[1], then drop rst_n for 2 cycles before the ack -> everything returns to reset values, and no load_ack follows the release.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: four-digit multiplexed seven-segment scan controller.
// Buttons load sw_val into their digit via fixed-priority arbitration, and
// the scan FSM steps across the digits once per refresh tick.
// Optional feature: define BTN_DEBOUNCE_EN to build per-button debounce
// counters. Without it, the synchronized button level is accepted directly.
module disp_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEB_CYCLES  = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic [3:0] sw_val,
  output logic [3:0] anodes,
  output logic [4:0] dig_code,
  output logic [3:0] load_ack
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  if (REFRESH_DIV < 2 || DEB_CYCLES < 2) begin : g_param_check
    $error("disp_scan_ctrl: REFRESH_DIV and DEB_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {S_OFF, S_D0, S_D1, S_D2, S_D3} state_t;

  state_t        state;
  logic [3:0]    sync1, sync2;
  logic [3:0]    level, level_q, rise;
  logic [3:0]    pending, grant;
  logic [4:0]    digit [4];
  logic [RW-1:0] ref_cnt;
  logic          tick;

  // Two-flop synchronizer on the raw buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt [4];

  // Accept a new level only after it has differed for DEB_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end
`else
  assign level = sync2;
`endif

  assign rise = level & ~level_q;

  // Fixed priority grant, index 3 highest
  always_comb begin
    grant = '0;
    if (pending[3])      grant = 4'b1000;
    else if (pending[2]) grant = 4'b0100;
    else if (pending[1]) grant = 4'b0010;
    else if (pending[0]) grant = 4'b0001;
  end

  // Edge capture, pending requests and digit loads; a new edge beats a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      pending  <= '0;
      load_ack <= '0;
      for (int i = 0; i < 4; i++) digit[i] <= 5'b11111;
    end else begin
      level_q  <= level;
      pending  <= (pending & ~grant) | rise;
      load_ack <= grant;
      for (int i = 0; i < 4; i++) begin
        if (grant[i]) digit[i] <= {1'b0, sw_val};
      end
    end
  end

  assign tick = (ref_cnt == REF_LAST);

  // Refresh divider, wraps after REFRESH_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_cnt <= '0;
    else        ref_cnt <= tick ? '0 : ref_cnt + RW'(1);
  end

  // Scan FSM with registered active-low anode enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_OFF;
      anodes <= 4'b1111;
    end else if (tick) begin
      case (state)
        S_OFF:   begin state <= S_D0;  anodes <= 4'b1110; end
        S_D0:    begin state <= S_D1;  anodes <= 4'b1101; end
        S_D1:    begin state <= S_D2;  anodes <= 4'b1011; end
        S_D2:    begin state <= S_D3;  anodes <= 4'b0111; end
        S_D3:    begin state <= S_D0;  anodes <= 4'b1110; end
        default: begin state <= S_OFF; anodes <= 4'b1111; end
      endcase
    end
  end

  // Digit select from registered state so it tracks anodes and digit writes
  always_comb begin
    dig_code = 5'b11111;
    case (state)
      S_D0:    dig_code = digit[0];
      S_D1:    dig_code = digit[1];
      S_D2:    dig_code = digit[2];
      S_D3:    dig_code = digit[3];
      default: dig_code = 5'b11111;
    endcase
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with REFRESH_DIV=4, DEB_CYCLES=8.
module tb_disp_scan_ctrl;

  localparam int REFRESH_DIV = 4;
  localparam int DEB_CYCLES  = 8;
`ifdef BTN_DEBOUNCE_EN
  localparam int ACK_STEP = 12;
`else
  localparam int ACK_STEP = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn = 4'h0;
  logic [3:0] sw_val = 4'h0;
  logic [3:0] anodes;
  logic [4:0] dig_code;
  logic [3:0] load_ack;

  int passes = 0;
  int total = 0;
  logic [4:0] exp_dig [4];

  always #5 clk = ~clk;

  disp_scan_ctrl #(.REFRESH_DIV(REFRESH_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .sw_val   (sw_val),
    .anodes   (anodes),
    .dig_code (dig_code),
    .load_ack (load_ack)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected anodes n cycles after reset release
  function automatic logic [3:0] scan_an(input int n);
    int idx;
    idx = n / 4;
    if (idx == 0) return 4'b1111;
    return ~(4'b0001 << ((idx - 1) % 4));
  endfunction

  task automatic check_disp(input string tag);
    logic [4:0] e;
    e = 5'h1f;
    case (anodes)
      4'b1111: e = 5'h1f;
      4'b1110: e = exp_dig[0];
      4'b1101: e = exp_dig[1];
      4'b1011: e = exp_dig[2];
      4'b0111: e = exp_dig[3];
      default: chk({tag, " anodes legal"}, {4'h0, anodes}, 8'h0f);
    endcase
    chk(tag, {3'b000, dig_code}, {3'b000, e});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " anodes"}, {4'h0, anodes}, 8'h0f);
    chk({tag, " dig_code"}, {3'b000, dig_code}, 8'h1f);
    chk({tag, " load_ack"}, {4'h0, load_ack}, 8'h00);
  endtask

  initial begin
    int n_ack;
    int first;
    logic [3:0] ackv;

    for (int i = 0; i < 4; i++) exp_dig[i] = 5'h1f;

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_async");
    step(); step(); step();
    check_reset_vals("rst_hold");

    // Scan sequence from reset release, nothing loaded
    rst_n = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      step();
      chk("r026 anodes", {4'h0, anodes}, {4'h0, scan_an(n)});
      chk("r026 dig_code", {3'b000, dig_code}, 8'h1f);
      chk("r026 load_ack", {4'h0, load_ack}, 8'h00);
    end

    // Single held press of button 0
    sw_val = 4'hA;
    btn = 4'b0001;
    n_ack = 0;
    first = 0;
    ackv = 4'h0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (load_ack != 4'h0) begin
        n_ack++;
        if (n_ack == 1) begin
          first = c;
          ackv = load_ack;
        end
        if (load_ack[0]) exp_dig[0] = 5'h0a;
      end
      check_disp("r027 disp");
    end
    chk("r027 ack count", 8'(n_ack), 8'd1);
    chk("r027 ack value", {4'h0, ackv}, 8'h01);
    chk("r027 ack latency", 8'(first), 8'(ACK_STEP));
    btn = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("r027 release no ack", {4'h0, load_ack}, 8'h00);
      check_disp("r027 release disp");
    end

    // Simultaneous press of buttons 3 and 0
    sw_val = 4'h5;
    btn = 4'b1001;
    first = 0;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      step();
      if (load_ack != 4'h0) first = c;
    end
    chk("r028 latency", 8'(first), 8'(ACK_STEP));
    chk("r028 ack3", {4'h0, load_ack}, 8'h08);
    exp_dig[3] = 5'h05;
    step();
    chk("r028 ack0", {4'h0, load_ack}, 8'h01);
    exp_dig[0] = 5'h05;
    step();
    chk("r028 ack idle", {4'h0, load_ack}, 8'h00);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("r028 hold no ack", {4'h0, load_ack}, 8'h00);
      check_disp("r028 disp");
    end
    btn = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("r028 release no ack", {4'h0, load_ack}, 8'h00);
    end

`ifndef BTN_DEBOUNCE_EN
    // Re-press of button 0 lands on its own grant cycle: the set must win
    sw_val = 4'hC;
    btn = 4'b1001;
    step();
    btn = 4'b1000;
    step();
    btn = 4'b1001;
    step();
    step();
    chk("setwin ack3", {4'h0, load_ack}, 8'h08);
    step();
    chk("setwin ack0 first", {4'h0, load_ack}, 8'h01);
    step();
    chk("setwin ack0 again", {4'h0, load_ack}, 8'h01);
    step();
    chk("setwin idle", {4'h0, load_ack}, 8'h00);
    exp_dig[3] = 5'h0c;
    exp_dig[0] = 5'h0c;
    btn = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("setwin no ack", {4'h0, load_ack}, 8'h00);
      check_disp("setwin disp");
    end
`else
    // Bouncing button 2 must never be accepted
    sw_val = 4'h3;
    for (int c = 0; c < 30; c++) begin
      btn[2] = ((c / 3) % 2 == 0);
      step();
      chk("r029 bounce no ack", {4'h0, load_ack}, 8'h00);
    end
    btn = 4'b0000;
    for (int c = 0; c < 30; c++) begin
      step();
      chk("r029 low no ack", {4'h0, load_ack}, 8'h00);
      check_disp("r029 disp");
    end
`endif

    // Reset in the middle of a pending button 1 request
    sw_val = 4'h7;
    btn = 4'b0010;
    step(); step(); step();
    chk("r030 pre-reset no ack", {4'h0, load_ack}, 8'h00);
    rst_n = 1'b0;
    btn = 4'b0000;
    #1 check_reset_vals("r030 rst_async");
    step(); step();
    check_reset_vals("r030 rst_hold");
    for (int i = 0; i < 4; i++) exp_dig[i] = 5'h1f;
    rst_n = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      step();
      chk("r030 no ack", {4'h0, load_ack}, 8'h00);
      chk("r030 anodes", {4'h0, anodes}, {4'h0, scan_an(n)});
      check_disp("r030 disp");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
